alu_serial_seq: RTL and testbench

//   Parametrised successor of the 8-bit serial-load ALU for the TT wrapper.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 48 ++++
 rtl/alu_serial_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_serial_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial-load ALU: op-codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after go.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   iter_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      iter_cnt <= '0;
      valid    <= 1'b0;
    end else if (go) begin
      mcand    <= {{WIDTH{1'b0}}, a};
      acc      <= '0;
      mplier   <= b;
      iter_cnt <= CNT_W'(WIDTH);
      valid    <= 1'b0;
    end else if (iter_cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      iter_cnt <= iter_cnt - 1'b1;
      // valid rises together with the final accumulate
      valid    <= (iter_cnt == CNT_W'(1));
    end else begin
      valid <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_serial_seq.sv
// Serial-load ALU with start/busy/done handshake and registered result/flags.
//   state   | meaning
//   IDLE    | waiting; operand loading allowed
//   EXEC    | single-cycle op evaluated on snapshot operands
//   MUL     | shift-add multiply running
//   DONE    | result/flags just updated; done high, loading/start allowed
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_in,
  input  logic               load_en,
  input  logic               sel_ab,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               start,
  input  logic               show_flags,
  output logic               a_full,
  output logic               b_full,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_out,
  output logic [3:0]         flags_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   reg_a, reg_b, op_a, op_b;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;

  logic               start_acc, mul_go, mul_valid;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]     sum, shl_w, shr_w;
  logic [WIDTH-1:0]   alu_res, mul_res;
  logic               alu_c, alu_v;
  logic [3:0]         alu_flags, mul_flags;

  assign busy      = (state_q == ST_EXEC) || (state_q == ST_MUL);
  assign done      = (state_q == ST_DONE);
  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mul_go    = start_acc && (op == OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start)                  state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
        else if (state_q == ST_DONE) state_d = ST_IDLE;
      end
      ST_EXEC: state_d = ST_DONE;
      ST_MUL:  if (mul_valid) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shift registers; an accepted start takes priority over a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a   <= '0;
      reg_b   <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_q    <= OP_ADD;
      shamt_q <= '0;
    end else if (start_acc) begin
      cnt_a   <= '0;
      cnt_b   <= '0;
      op_a    <= reg_a;
      op_b    <= reg_b;
      op_q    <= op;
      shamt_q <= shamt;
    end else if (load_en && !busy) begin
      if (sel_ab) begin
        reg_b <= {reg_b[WIDTH-2:0], bit_in};
        if (cnt_b != CNT_FULL) cnt_b <= cnt_b + 1'b1;
      end else begin
        reg_a <= {reg_a[WIDTH-2:0], bit_in};
        if (cnt_a != CNT_FULL) cnt_a <= cnt_a + 1'b1;
      end
    end
  end

  assign a_full = (cnt_a == CNT_FULL);
  assign b_full = (cnt_b == CNT_FULL);

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    // Extra bit on each side catches the last bit shifted out
    shl_w   = {1'b0, op_a} << shamt_q;
    shr_w   = {op_a, 1'b0} >> shamt_q;
    case (op_q)
      OP_ADD: begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, op_a} - {1'b0, op_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
  assign mul_res   = product[WIDTH-1:0];
  assign mul_flags = {(mul_res == '0), mul_res[WIDTH-1], |product[2*WIDTH-1:WIDTH], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state_q == ST_EXEC) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
    end else if ((state_q == ST_MUL) && mul_valid) begin
      result_q <= mul_res;
      flags_q  <= mul_flags;
    end
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (mul_go),
    .a       (reg_a),
    .b       (reg_b),
    .product (product),
    .valid   (mul_valid)
  );

  assign flags_out  = flags_q;
  assign result_out = show_flags ? {{(WIDTH-4){1'b0}}, flags_q} : result_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed plus random checks of alu_serial_seq against an arithmetic reference model.
module tb_alu_serial_seq;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR  = 3'd3;
  localparam logic [2:0] T_SHL = 3'd4, T_SHR = 3'd5, T_XOR = 3'd6, T_MUL = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_in = 1'b0, load_en = 1'b0, sel_ab = 1'b0, start = 1'b0, show_flags = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [2:0]   shamt = 3'd0;
  logic         a_full, b_full, busy, done;
  logic [W-1:0] result_out;
  logic [3:0]   flags_out;

  int n_assert = 0;
  int n_fail   = 0;
  int ma = 0, mb = 0, ca = 0, cb = 0;   // model operand values and load counts

  alu_serial_seq #(.WIDTH(W), .SHAMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .load_en(load_en), .sel_ab(sel_ab),
    .op(op), .shamt(shamt), .start(start), .show_flags(show_flags),
    .a_full(a_full), .b_full(b_full), .busy(busy), .done(done),
    .result_out(result_out), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= (1 << (W-1))) ? x - (1 << W) : x;
  endfunction

  // Reference: result and {Z,N,C,V} from plain integer arithmetic
  function automatic void model(input int a, input int b, input int o, input int s,
                                output int r, output int f);
    int c, v, full, sr;
    c = 0; v = 0; full = 0; sr = 0;
    case (o)
      0: begin full = a + b; c = (full > MASK); sr = sgn(a) + sgn(b);
               v = (sr > MASK/2) || (sr < -(MASK/2) - 1); end
      1: begin full = a - b; c = (a < b); sr = sgn(a) - sgn(b);
               v = (sr > MASK/2) || (sr < -(MASK/2) - 1); end
      2: full = a & b;
      3: full = a | b;
      4: begin full = a << s; c = (s > 0) ? ((a >> (W - s)) & 1) : 0; end
      5: begin full = a >> s; c = (s > 0) ? ((a >> (s - 1)) & 1) : 0; end
      6: full = a ^ b;
      default: begin full = a * b; c = (full > MASK); end
    endcase
    r = full & MASK;
    f = ((r == 0) << 3) | (((r >> (W-1)) & 1) << 2) | (c << 1) | v;
  endfunction

  task automatic load(input bit sel, input int value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sel_ab  = sel;
      bit_in  = (value >> i) & 1;
      load_en = 1'b1;
      @(negedge clk);
      if (sel) begin mb = ((mb << 1) | ((value >> i) & 1)) & MASK; if (cb < W) cb++; end
      else     begin ma = ((ma << 1) | ((value >> i) & 1)) & MASK; if (ca < W) ca++; end
    end
    load_en = 1'b0;
    chk("a_full", a_full, (ca == W));
    chk("b_full", b_full, (cb == W));
  endtask

  task automatic run_op(input logic [2:0] o, input int s, input bit poke, input bit with_load);
    int r, f, lat;
    model(ma, mb, o, s, r, f);
    op = o; shamt = s[2:0]; start = 1'b1;
    if (with_load) begin load_en = 1'b1; sel_ab = 1'b0; bit_in = ~ma[0]; end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    ca = 0; cb = 0;
    lat = 1;
    chk("busy_exec", busy, 1'b1);
    while (!done && lat < W + 8) begin
      if (poke && lat == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk("latency", lat, (o == T_MUL) ? W + 2 : 2);
    chk("result", result_out, r);
    chk("flags", flags_out, f);
    chk("busy_done", busy, 1'b0);
    chk("cnt_clr_a", a_full, 1'b0);
    chk("cnt_clr_b", b_full, 1'b0);
    show_flags = 1'b1;
    #1 chk("flag_view", result_out, f);
    show_flags = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("result_hold", result_out, r);
  endtask

  initial begin
    int seen_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_result", result_out, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_afull", a_full, 0);

    load(0, 8'h7F, 8); load(1, 8'h01, 8);
    run_op(T_ADD, 0, 0, 0);
    chk("add_const", result_out, 8'h80);
    run_op(T_SUB, 0, 0, 0);

    // Reset in the middle of a multiply
    load(0, 8'h10, 8); load(1, 8'h20, 8);
    op = T_MUL; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_result", result_out, 0);
    chk("mrst_flags", flags_out, 0);
    chk("mrst_afull", a_full, 0);
    chk("mrst_bfull", b_full, 0);
    @(negedge clk); rst_n = 1'b1;
    ma = 0; mb = 0; ca = 0; cb = 0;
    seen_done = 0;
    repeat (W + 4) begin @(negedge clk); if (done) seen_done = 1; end
    chk("mrst_no_done", seen_done, 0);
    chk("mrst_result2", result_out, 0);

    load(0, 8'h03, 8); load(1, 8'h05, 8);
    run_op(T_SUB, 0, 0, 0);
    show_flags = 1'b1;
    #1 chk("flag_view_06", result_out, 8'h06);
    show_flags = 1'b0;

    load(0, 8'h81, 8);
    run_op(T_SHL, 1, 0, 0);
    run_op(T_SHR, 0, 0, 0);

    load(0, 8'h10, 8); load(1, 8'h20, 8);
    run_op(T_MUL, 0, 0, 0);
    load(0, 8'h0F, 8); load(1, 8'h0F, 8);
    run_op(T_MUL, 0, 1, 0);
    chk("mul_const", result_out, 8'hE1);

    // Sliding window: 10 bits into A, then start coinciding with a load
    load(1, 8'h00, 8);
    load(0, 10'h35A >> 3, 7);
    load(0, 10'h35A >> 2, 1);
    load(0, 10'h35A, 2);
    run_op(T_OR, 0, 0, 0);
    chk("window_a", result_out, 8'h5A);
    run_op(T_OR, 0, 0, 1);
    run_op(T_OR, 0, 0, 0);
    chk("load_dropped", result_out, 8'h5A);

    for (int k = 0; k < 24; k++) begin
      load(0, $urandom_range(0, MASK), W);
      load(1, $urandom_range(0, MASK), W);
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, W - 1), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
